// File: rtl/hazard_forward_unit_if.sv
// Bundle between the decode stage and the hazard/forwarding unit.
// master: decode/execute side driving FD fields; slave: the hazard unit.
interface hazard_forward_unit_if #(
  parameter int AW = 5
);
  logic          fd_valid;
  logic [AW-1:0] fd_rs1;
  logic [AW-1:0] fd_rs2;
  logic          fd_use_rs1;
  logic          fd_use_rs2;
  logic [AW-1:0] fd_rd;
  logic          fd_writes;
  logic          fd_is_load;
  logic          fd_is_store;
  logic          fd_is_md;
  logic          ex_flush;
  logic          ex_status_wr;
  logic          stall;
  logic [1:0]    sel_a;
  logic [1:0]    sel_b;
  logic          wm_bypass;
  logic          md_busy;

  modport master (
    output fd_valid, fd_rs1, fd_rs2, fd_use_rs1, fd_use_rs2, fd_rd,
           fd_writes, fd_is_load, fd_is_store, fd_is_md, ex_flush, ex_status_wr,
    input  stall, sel_a, sel_b, wm_bypass, md_busy
  );

  modport slave (
    input  fd_valid, fd_rs1, fd_rs2, fd_use_rs1, fd_use_rs2, fd_rd,
           fd_writes, fd_is_load, fd_is_store, fd_is_md, ex_flush, ex_status_wr,
    output stall, sel_a, sel_b, wm_bypass, md_busy
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline. Tracks a shadow
// copy of the DX/XM/MW destination tags and derives operand selects, the
// XM store-data bypass, load-use stalls and mult/div hold stalls.
// Optional feature macro: STATUS_R30_FWD_EN -- an exception raised by the
// DX op becomes an implicit second write to STATUS_REG that forwarding sees.
module hazard_forward_unit #(
  parameter int AW         = 5,
  parameter int MD_LATENCY = 33,
  parameter int STATUS_REG = 30
) (
  input  logic               clock,
  input  logic               reset,
  hazard_forward_unit_if.slave bus
);

  localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CW-1:0] MD_LOAD    = CW'(MD_LATENCY - 1);
  localparam logic [AW-1:0] STATUS_IDX = AW'(STATUS_REG);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          writes;
    logic          is_load;
    logic          is_store;
    logic          use_rs1;
    logic          use_rs2;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          is_md;
  } dx_rec_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          writes;
    logic          status_wr;
    logic          is_store;
    logic [AW-1:0] rs2;
  } xm_rec_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          writes;
    logic          status_wr;
  } mw_rec_t;

  dx_rec_t       dx_reg;
  xm_rec_t       xm_reg;
  mw_rec_t       mw_reg;
  logic [CW-1:0] md_cnt_reg;

  dx_rec_t       fd_rec;
  logic          status_capture;
  logic          load_use;
  logic          md_hold;
  logic [AW-1:0] dx_src [2];
  logic          dx_use [2];
  logic [1:0]    sel_w  [2];

  // An in-flight XM/MW instruction produces src if it writes it, or if it
  // carries the implicit status write and src is the status register.
  function automatic logic xm_hits(input xm_rec_t r, input logic [AW-1:0] src);
    return (src != '0) && r.valid &&
           ((r.writes && (r.rd == src)) || (r.status_wr && (src == STATUS_IDX)));
  endfunction

  function automatic logic mw_hits(input mw_rec_t r, input logic [AW-1:0] src);
    return (src != '0) && r.valid &&
           ((r.writes && (r.rd == src)) || (r.status_wr && (src == STATUS_IDX)));
  endfunction

`ifdef STATUS_R30_FWD_EN
  assign status_capture = dx_reg.valid & bus.ex_status_wr;
`else
  logic unused_status_wr;
  assign unused_status_wr = bus.ex_status_wr;
  assign status_capture   = 1'b0;
`endif

  assign fd_rec = '{
    valid:    1'b1,
    rd:       bus.fd_rd,
    writes:   bus.fd_writes,
    is_load:  bus.fd_is_load,
    is_store: bus.fd_is_store,
    use_rs1:  bus.fd_use_rs1,
    use_rs2:  bus.fd_use_rs2,
    rs1:      bus.fd_rs1,
    rs2:      bus.fd_rs2,
    is_md:    bus.fd_is_md
  };

  // The counter is only nonzero while a mult/div sits in DX.
  assign md_hold = dx_reg.valid && dx_reg.is_md && (md_cnt_reg != '0);

  assign load_use = dx_reg.valid && dx_reg.is_load && (dx_reg.rd != '0) && bus.fd_valid &&
                    ((bus.fd_use_rs1 && (bus.fd_rs1 == dx_reg.rd)) ||
                     (bus.fd_use_rs2 && (bus.fd_rs2 == dx_reg.rd)));

  assign dx_src[0] = dx_reg.rs1;
  assign dx_src[1] = dx_reg.rs2;
  assign dx_use[0] = dx_reg.use_rs1;
  assign dx_use[1] = dx_reg.use_rs2;

  // Operand select per DX source: nearest older producer wins (MX over WX).
  for (genvar gi = 0; gi < 2; gi++) begin : g_sel
    assign sel_w[gi] = !(dx_reg.valid && dx_use[gi]) ? 2'd0 :
                       xm_hits(xm_reg, dx_src[gi])   ? 2'd1 :
                       mw_hits(mw_reg, dx_src[gi])   ? 2'd2 : 2'd0;
  end

  assign bus.sel_a     = sel_w[0];
  assign bus.sel_b     = sel_w[1];
  assign bus.stall     = md_hold | load_use;
  assign bus.md_busy   = md_hold;
  assign bus.wm_bypass = xm_reg.valid && xm_reg.is_store && mw_hits(mw_reg, xm_reg.rs2);

  // Shadow pipeline advance: mult/div hold, load-use bubble, or normal flow.
  always_ff @(posedge clock) begin
    if (reset) begin
      dx_reg     <= '0;
      xm_reg     <= '0;
      mw_reg     <= '0;
      md_cnt_reg <= '0;
    end else begin
      mw_reg.valid     <= xm_reg.valid;
      mw_reg.rd        <= xm_reg.rd;
      mw_reg.writes    <= xm_reg.writes;
      mw_reg.status_wr <= xm_reg.status_wr;
      if (md_hold) begin
        // DX and FD frozen; ex_flush cannot legally occur here and is ignored.
        xm_reg     <= '0;
        md_cnt_reg <= md_cnt_reg - CW'(1);
      end else begin
        xm_reg.valid     <= dx_reg.valid;
        xm_reg.rd        <= dx_reg.rd;
        xm_reg.writes    <= dx_reg.writes;
        xm_reg.status_wr <= status_capture;
        xm_reg.is_store  <= dx_reg.is_store;
        xm_reg.rs2       <= dx_reg.rs2;
        if (load_use) begin
          dx_reg <= '0;
        end else if (bus.fd_valid && !bus.ex_flush) begin
          dx_reg     <= fd_rec;
          md_cnt_reg <= bus.fd_is_md ? MD_LOAD : '0;
        end else begin
          dx_reg <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline scenarios
// with literal expectations, then randomized instruction streams checked
// every cycle against an instruction-level model of the pipeline.
// Build with STATUS_R30_FWD_EN defined to exercise the status forwarding.
module tb_hazard_forward_unit;
  localparam int AW     = 5;
  localparam int MD_LAT = 33;
  localparam int SREG   = 30;
`ifdef STATUS_R30_FWD_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_forward_unit_if #(.AW(AW)) hif ();

  hazard_forward_unit #(.AW(AW), .MD_LATENCY(MD_LAT), .STATUS_REG(SREG)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (hif)
  );

  typedef struct {
    bit v; int rd; bit wr; bit ld; bit st; bit u1; bit u2; int rs1; int rs2; bit md; bit stat;
  } ins_t;

  ins_t stg [1:3];   // 1 = DX, 2 = XM, 3 = MW
  int   md_left;
  bit   model_stall;
  int   checks = 0;
  int   errors = 0;
  logic       last_stall, last_busy, last_wm;
  logic [1:0] last_sa, last_sb;

  function automatic ins_t nop();
    ins_t i = '{default: 0};
    return i;
  endfunction

  function automatic ins_t mk(input int rd, input bit wr, input int rs1, input bit u1,
                              input int rs2, input bit u2, input bit ld = 1'b0,
                              input bit st = 1'b0, input bit md = 1'b0);
    ins_t i = '{default: 0};
    i.v = 1'b1; i.rd = rd; i.wr = wr; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
    i.ld = ld; i.st = st; i.md = md;
    return i;
  endfunction

  function automatic ins_t alu(input int rd, input int rs1, input int rs2);
    return mk(rd, 1'b1, rs1, 1'b1, rs2, 1'b1);
  endfunction

  function automatic int pick_reg();
    int t = $urandom_range(0, 4);
    return (t == 4) ? SREG : t;
  endfunction

  function automatic ins_t rnd();
    ins_t i;
    int   k = $urandom_range(0, 99);
    if (k < 2)       i = mk(pick_reg(), 1'b1, pick_reg(), 1'b1, pick_reg(), 1'b1, 1'b0, 1'b0, 1'b1);
    else if (k < 22) i = mk(pick_reg(), 1'b1, pick_reg(), 1'b1, pick_reg(), 1'b0, 1'b1);
    else if (k < 38) i = mk(pick_reg(), 1'b0, pick_reg(), 1'b1, pick_reg(), 1'b1, 1'b0, 1'b1);
    else             i = mk(pick_reg(), 1'($urandom_range(0, 1)), pick_reg(),
                            1'($urandom_range(0, 1)), pick_reg(), 1'($urandom_range(0, 1)));
    if ($urandom_range(0, 7) == 0) i.v = 1'b0;
    return i;
  endfunction

  // Does an in-flight instruction deliver a value for architectural register r?
  function automatic bit produces(input ins_t i, input int r);
    return i.v && (r != 0) && ((i.wr && i.rd == r) || (STAT_EN && i.stat && r == SREG));
  endfunction

  // Nearest older instruction (XM first, then MW) that produces src.
  function automatic int want_sel(input int src, input bit use_it);
    if (!stg[1].v || !use_it || src == 0) return 0;
    for (int s = 2; s <= 3; s++)
      if (produces(stg[s], src)) return s - 1;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 1; s <= 3; s++) stg[s] = nop();
    md_left = 0;
  endtask

  // One clock cycle: drive FD at the falling edge, compare the DUT against
  // the model just after, then step the model to match the coming edge.
  task automatic cyc(input ins_t fd, input bit flush, input bit stat, input bit rst);
    bit busy, lu, stl;
    reset            = rst;
    hif.fd_valid     = fd.v;
    hif.fd_rs1       = AW'(fd.rs1);
    hif.fd_rs2       = AW'(fd.rs2);
    hif.fd_use_rs1   = fd.u1;
    hif.fd_use_rs2   = fd.u2;
    hif.fd_rd        = AW'(fd.rd);
    hif.fd_writes    = fd.wr;
    hif.fd_is_load   = fd.ld;
    hif.fd_is_store  = fd.st;
    hif.fd_is_md     = fd.md;
    hif.ex_flush     = flush;
    hif.ex_status_wr = stat;
    #1;
    busy = (md_left > 0);
    lu   = stg[1].v && stg[1].ld && stg[1].rd != 0 && fd.v &&
           ((fd.u1 && fd.rs1 == stg[1].rd) || (fd.u2 && fd.rs2 == stg[1].rd));
    stl  = busy || lu;
    last_stall = hif.stall;
    last_busy  = hif.md_busy;
    last_sa    = hif.sel_a;
    last_sb    = hif.sel_b;
    last_wm    = hif.wm_bypass;
    chk("stall", hif.stall, stl);
    chk("md_busy", hif.md_busy, busy);
    chk("sel_a", hif.sel_a, want_sel(stg[1].rs1, stg[1].u1));
    chk("sel_b", hif.sel_b, want_sel(stg[1].rs2, stg[1].u2));
    chk("wm_bypass", hif.wm_bypass, stg[2].v && stg[2].st && produces(stg[3], stg[2].rs2));
    model_stall = stl;
    if (rst) begin
      model_clear();
    end else if (busy) begin
      stg[3] = stg[2];
      stg[2] = nop();
      md_left--;
    end else begin
      stg[3]      = stg[2];
      stg[2]      = stg[1];
      stg[2].stat = stg[1].v && stat;
      if (!lu && fd.v && !flush) begin
        stg[1]      = fd;
        stg[1].stat = 1'b0;
        if (fd.md) md_left = MD_LAT - 1;
      end else begin
        stg[1] = nop();
      end
    end
    @(negedge clock);
  endtask

  task automatic drain();
    repeat (4) cyc(nop(), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int   n_stall, n_busy;
    ins_t cur;
    reset = 1'b1;
    hif.fd_valid = 1'b0; hif.fd_rs1 = '0; hif.fd_rs2 = '0; hif.fd_use_rs1 = 1'b0;
    hif.fd_use_rs2 = 1'b0; hif.fd_rd = '0; hif.fd_writes = 1'b0; hif.fd_is_load = 1'b0;
    hif.fd_is_store = 1'b0; hif.fd_is_md = 1'b0; hif.ex_flush = 1'b0; hif.ex_status_wr = 1'b0;
    model_clear();
    model_stall = 1'b0;
    @(negedge clock);
    cyc(nop(), 1'b0, 1'b0, 1'b1);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("reset_stall", last_stall, 0);
    chk("reset_busy", last_busy, 0);
    chk("reset_sel_a", last_sa, 0);
    chk("reset_wm", last_wm, 0);

    // add r3,r1,r2 ; add r4,r3,r3 -> both operands from XM
    cyc(alu(3, 1, 2), 1'b0, 1'b0, 1'b0);
    cyc(alu(4, 3, 3), 1'b0, 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("mx_sel_a", last_sa, 1);
    chk("mx_sel_b", last_sb, 1);
    chk("mx_stall", last_stall, 0);
    drain();

    // add r3 ; nop ; sub r5,r3,r0 -> rs1 from MW, r0 never forwarded
    cyc(alu(3, 1, 2), 1'b0, 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    cyc(alu(5, 3, 0), 1'b0, 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("wx_sel_a", last_sa, 2);
    chk("wx_r0_sel_b", last_sb, 0);
    drain();

    // add r0 ; add r4,r0,r0 -> writes to r0 are never forwarded
    cyc(alu(0, 1, 2), 1'b0, 1'b0, 1'b0);
    cyc(alu(4, 0, 0), 1'b0, 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("r0_sel_a", last_sa, 0);
    chk("r0_sel_b", last_sb, 0);
    drain();

    // flushed producer never enters DX, so its consumer reads the regfile
    cyc(alu(3, 1, 2), 1'b1, 1'b0, 1'b0);
    cyc(alu(4, 3, 3), 1'b0, 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("flush_sel_a", last_sa, 0);
    drain();

    // lw r6 ; add r7,r6,r2 -> one bubble, then WX
    cyc(mk(6, 1'b1, 1, 1'b1, 0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    cyc(alu(7, 6, 2), 1'b0, 1'b0, 1'b0);
    chk("lu_stall_on", last_stall, 1);
    cyc(alu(7, 6, 2), 1'b0, 1'b0, 1'b0);
    chk("lu_stall_off", last_stall, 0);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("lu_sel_a", last_sa, 2);
    drain();

    // mul r8 ; add r9,r8,r8 -> 32 hold cycles, then MX
    cyc(mk(8, 1'b1, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    n_stall = 0;
    n_busy  = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(alu(9, 8, 8), 1'b0, 1'b0, 1'b0);
      if (last_busy === 1'b1) n_busy++;
      if (last_stall === 1'b1) n_stall++;
      else break;
    end
    chk("md_stall_cycles", n_stall, MD_LAT - 1);
    chk("md_busy_cycles", n_busy, MD_LAT - 1);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("md_sel_a", last_sa, 1);
    chk("md_sel_b", last_sb, 1);
    drain();

    // addi r10 ; sw r10 back to back -> MX in DX, then XM store bypass
    cyc(mk(10, 1'b1, 1, 1'b1, 0, 1'b0), 1'b0, 1'b0, 1'b0);
    cyc(mk(0, 1'b0, 2, 1'b1, 10, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("st_sel_b", last_sb, 1);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("st_wm_on", last_wm, 1);
    drain();

    // addi r10 ; nop ; sw r10 -> WX in DX, producer gone by the time sw is in XM
    cyc(mk(10, 1'b1, 1, 1'b1, 0, 1'b0), 1'b0, 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    cyc(mk(0, 1'b0, 2, 1'b1, 10, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("st1_sel_b", last_sb, 2);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("st1_wm_off", last_wm, 0);
    drain();

    // reset during a mult/div hold clears everything on that edge
    cyc(mk(8, 1'b1, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(nop(), 1'b0, 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0, 1'b1);
    cyc(alu(9, 8, 8), 1'b0, 1'b0, 1'b0);
    chk("rst_md_busy", last_busy, 0);
    chk("rst_md_stall", last_stall, 0);
    chk("rst_md_sel_a", last_sa, 0);
    drain();

`ifdef STATUS_R30_FWD_EN
    // add raises exception in DX ; bne r5,r30 -> status arrives via MX
    cyc(alu(3, 1, 2), 1'b0, 1'b0, 1'b0);
    cyc(mk(0, 1'b0, 5, 1'b1, SREG, 1'b1), 1'b0, 1'b1, 1'b0);
    cyc(nop(), 1'b0, 1'b0, 1'b0);
    chk("status_sel_b", last_sb, 1);
    chk("status_sel_a", last_sa, 0);
    drain();
`endif

    // randomized streams; FD is held whenever the model says the front end stalls
    cur = nop();
    for (int k = 0; k < 2500; k++) begin
      if (!model_stall) cur = rnd();
      cyc(cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
